// File: rtl/pipe_scroller_if.sv
// rtl/pipe_scroller_if.sv - game-control inputs and obstacle-layer outputs of the pipe scroller
interface pipe_scroller_if;
  logic               enable;
  logic               gameover;
  logic [15:0][15:0]  red_array;
  logic               tick;
  logic               pipe_passed;

  modport master (
    output enable, gameover,
    input  red_array, tick, pipe_passed
  );

  modport slave (
    input  enable, gameover,
    output red_array, tick, pipe_passed
  );
endinterface

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolling pipe obstacle layer for the 16x16 LED game matrix
module pipe_scroller #(
  parameter int         TICK_DIV     = 12_500_000,
  parameter int         GAP_H        = 4,
  parameter int         PIPE_SPACING = 6,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  pipe_scroller_if.slave bus
);
  localparam int             CW         = $clog2(TICK_DIV);
  localparam int             SW         = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [CW-1:0]  TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0]  SPACE_LAST = SW'(PIPE_SPACING - 1);
  localparam logic [4:0]     GAP_LIM    = 5'(16 - GAP_H);
  localparam logic [4:0]     GAP_LEN    = 5'(GAP_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_run_hold;
  logic              w_clear;
  logic              w_step;
  logic [CW-1:0]     r_tick_cnt;
  logic [SW-1:0]     r_space_cnt;
  logic [7:0]        r_lfsr;
  logic [15:0][15:0] r_red;
  logic              r_tick;
  logic              r_pass;
  logic [4:0]        w_v;
  logic [4:0]        w_gap_top;
  logic [4:0]        w_gap_end;
  logic [15:0]       w_new_col;
  logic              w_col14_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.enable) w_next = S_RUN;
      S_RUN: begin
        if (bus.gameover)     w_next = S_FROZEN;
        else if (!bus.enable) w_next = S_IDLE;
      end
      S_FROZEN: if (!bus.enable) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // A step only happens on an edge that stays in RUN, so freeze/stop never scrolls.
  always_comb begin
    w_run_hold = (r_state == S_RUN) && (w_next == S_RUN);
    w_clear    = (r_state != S_IDLE) && (w_next == S_IDLE);
  end

  assign w_step = w_run_hold && (r_tick_cnt == TICK_LAST);

  // Gap is folded back into range rather than wrapped past row 15.
  always_comb begin
    w_v         = {1'b0, r_lfsr[3:0]};
    w_gap_top   = (w_v <= GAP_LIM) ? w_v : (w_v - GAP_LIM);
    w_gap_end   = w_gap_top + GAP_LEN;
    w_new_col   = '0;
    w_col14_any = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (r_space_cnt == '0) begin
        w_new_col[r] = !((5'(r) >= w_gap_top) && (5'(r) < w_gap_end));
      end
      w_col14_any = w_col14_any | r_red[r][14];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt  <= '0;
      r_space_cnt <= '0;
      r_lfsr      <= SEED;
      r_red       <= '0;
      r_tick      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_pass <= w_step && w_col14_any;
      if (w_run_hold) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : (r_tick_cnt + CW'(1));
      end else begin
        r_tick_cnt <= '0;
      end
      if (w_clear) begin
        r_red <= '0;
      end else if (w_step) begin
        for (int r = 0; r < 16; r++) begin
          r_red[r] <= {r_red[r][14:0], w_new_col[r]};
        end
        if (r_space_cnt == '0) begin
          r_space_cnt <= SPACE_LAST;
          r_lfsr      <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end else begin
          r_space_cnt <= r_space_cnt - SW'(1);
        end
      end
    end
  end

  assign bus.red_array   = r_red;
  assign bus.tick        = r_tick;
  assign bus.pipe_passed = r_pass;
endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - self-checking bench for pipe_scroller with directed table and random model
module tb_pipe_scroller;
  localparam int         TICK_DIV     = 4;
  localparam int         GAP_H        = 4;
  localparam int         PIPE_SPACING = 6;
  localparam logic [7:0] SEED         = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   model_on = 0;

  pipe_scroller_if bus ();

  pipe_scroller #(
    .TICK_DIV(TICK_DIV), .GAP_H(GAP_H), .PIPE_SPACING(PIPE_SPACING), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] col_of(input logic [15:0][15:0] f, input int c);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = f[r][c];
    return v;
  endfunction

  // Reference model: game mode, edges spent in RUN, total steps since reset.
  int                m_mode;
  int                m_run_edges;
  int                m_steps;
  logic [7:0]        m_lfsr;
  logic [15:0][15:0] m_red;
  logic              m_tick;
  logic              m_pass;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int ones;
    ones = int'(s[7]) + int'(s[5]) + int'(s[4]) + int'(s[3]);
    return {s[6:0], 1'(ones % 2)};
  endfunction

  function automatic logic [15:0] spawn_col(input logic [7:0] s);
    int v, top;
    logic [15:0] c;
    v   = int'(s) % 16;
    top = (v <= 16 - GAP_H) ? v : v - (16 - GAP_H);
    for (int r = 0; r < 16; r++) c[r] = (r < top) || (r >= top + GAP_H);
    return c;
  endfunction

  task automatic model_step();
    logic [15:0] nc;
    m_pass = 1'b0;
    for (int r = 0; r < 16; r++) if (m_red[r][14]) m_pass = 1'b1;
    nc = '0;
    if (m_steps % PIPE_SPACING == 0) begin
      nc     = spawn_col(m_lfsr);
      m_lfsr = lfsr_next(m_lfsr);
    end
    for (int r = 0; r < 16; r++) begin
      for (int c = 15; c >= 1; c--) m_red[r][c] = m_red[r][c-1];
      m_red[r][0] = nc[r];
    end
    m_steps++;
    m_tick = 1'b1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_run_edges = 0; m_steps = 0; m_lfsr = SEED;
      m_red = '0; m_tick = 1'b0; m_pass = 1'b0;
    end else begin
      m_tick = 1'b0;
      m_pass = 1'b0;
      case (m_mode)
        0: if (bus.enable) begin m_mode = 1; m_run_edges = 0; end
        1: begin
          if (bus.gameover) m_mode = 2;
          else if (!bus.enable) begin m_mode = 0; m_red = '0; end
          else begin
            m_run_edges++;
            if (m_run_edges % TICK_DIV == 0) model_step();
          end
        end
        default: if (!bus.enable) begin m_mode = 0; m_red = '0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_frame", bus.red_array, m_red);
      chk("model_tick", 256'(bus.tick), 256'(m_tick));
      chk("model_pass", 256'(bus.pipe_passed), 256'(m_pass));
    end
  end

  typedef struct {
    int          edges;
    int          col;
    logic [15:0] exp_col;
    logic        exp_tick;
    logic        exp_pass;
  } vec_t;

  vec_t tbl [0:12];

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.tick && n < 50) begin @(negedge clk); n++; end
    if (!bus.tick) begin
      n_checks++; n_errors++;
      $display("FAIL %s: got no tick within 50 cycles expected tick", name);
    end
  endtask

  logic [15:0][15:0] saved;
  bit                seen;

  initial begin
    tbl[0]  = '{4,  0,  16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1,  0,  16'hFE1F, 1'b1, 1'b0};
    tbl[2]  = '{0,  1,  16'h0000, 1'b1, 1'b0};
    tbl[3]  = '{1,  0,  16'hFE1F, 1'b0, 1'b0};
    tbl[4]  = '{19, 5,  16'hFE1F, 1'b1, 1'b0};
    tbl[5]  = '{0,  0,  16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{4,  6,  16'hFE1F, 1'b1, 1'b0};
    tbl[7]  = '{0,  0,  16'hC3FF, 1'b1, 1'b0};
    tbl[8]  = '{0,  3,  16'h0000, 1'b1, 1'b0};
    tbl[9]  = '{32, 14, 16'hFE1F, 1'b1, 1'b0};
    tbl[10] = '{4,  15, 16'hFE1F, 1'b1, 1'b1};
    tbl[11] = '{1,  15, 16'hFE1F, 1'b0, 1'b0};
    tbl[12] = '{3,  15, 16'h0000, 1'b1, 1'b0};

    reset = 1'b0; bus.enable = 1'b0; bus.gameover = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_frame", bus.red_array, '0);
    chk("reset_tick", 256'(bus.tick), 256'(0));
    chk("reset_pass", 256'(bus.pipe_passed), 256'(0));
    model_on = 1;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) bus.enable = 1'b1;

    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].edges) @(negedge clk);
      chk($sformatf("vec%0d_col%0d", i, tbl[i].col), 256'(col_of(bus.red_array, tbl[i].col)), 256'(tbl[i].exp_col));
      chk($sformatf("vec%0d_tick", i), 256'(bus.tick), 256'(tbl[i].exp_tick));
      chk($sformatf("vec%0d_pass", i), 256'(bus.pipe_passed), 256'(tbl[i].exp_pass));
    end

    // Freeze: a one-cycle gameover must hold the frame until enable drops.
    bus.gameover = 1'b1;
    @(negedge clk) bus.gameover = 1'b0;
    saved = bus.red_array;
    seen  = 0;
    repeat (20) @(negedge clk) if (bus.tick || bus.pipe_passed) seen = 1;
    chk("freeze_frame", bus.red_array, saved);
    chk("freeze_nonzero", 256'(saved != '0), 256'(1));
    chk("freeze_no_pulse", 256'(seen), 256'(0));
    bus.enable = 1'b0;
    @(negedge clk);
    chk("freeze_clear", bus.red_array, '0);

    // Priority: gameover and enable=0 on the same edge freezes first.
    bus.enable = 1'b1;
    for (int k = 0; k < 20 && bus.red_array == '0; k++) wait_tick("prio_wait");
    saved = bus.red_array;
    bus.enable = 1'b0; bus.gameover = 1'b1;
    @(negedge clk);
    chk("prio_held", bus.red_array, saved);
    chk("prio_nonzero", 256'(saved != '0), 256'(1));
    bus.gameover = 1'b0;
    @(negedge clk);
    chk("prio_clear_next", bus.red_array, '0);

    // Async reset two edges after a step, between clock edges.
    bus.enable = 1'b1;
    wait_tick("areset_wait0");
    for (int k = 0; k < 20 && bus.red_array == '0; k++) wait_tick("areset_wait");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_frame", bus.red_array, '0);
    chk("areset_tick", 256'(bus.tick), 256'(0));
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("areset_respawn_col0", 256'(col_of(bus.red_array, 0)), 256'(16'hFE1F));
    chk("areset_respawn_tick", 256'(bus.tick), 256'(1));

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.enable   = ($urandom_range(0, 99) < 95);
      bus.gameover = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 599) == 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
